fifo_burst_rd_ctrl: RTL and testbench

Read-side burst scheduler for the 8-in/16-out asynchronous FIFO. Watches the FIFO read water level, requests a downstream burst slot (e.g. DDR write port) once enough 16-bit words are queued, then drains exactly the granted burst through a valid/ready stream. A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency under backpressure.

---
 rtl/fifo_burst_pkg.sv | 21 ++
 rtl/fifo_skid_buf.sv | 59 +++++
 rtl/fifo_burst_rd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fifo_burst_rd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg: shared types and constants for the FIFO read-side burst
// scheduler (controller FSM states, water-level width helper).
package fifo_burst_pkg;

    // Default FIFO read address width; the water level carries one extra bit.
    localparam int RD_DEPTH_WIDTH_DEF = 13;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } burst_state_t;

    // Water level / burst length / counter width for a given address width.
    function automatic int lvl_width(input int depth_w);
        return depth_w + 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry skid buffer between the FIFO read port and the
// output stream. Absorbs the one-cycle FIFO read latency under backpressure.
// Simultaneous push and pop are both applied.
module fifo_skid_buf
    import fifo_burst_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              tb_rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_occ;
    logic              w_push_ok;
    logic              w_pop_ok;

    // The controller never pushes into a full buffer or pops an empty one;
    // the guards keep the pointers coherent regardless.
    assign w_push_ok = i_push && (r_occ != 2'd2);
    assign w_pop_ok  = i_pop  && (r_occ != 2'd0);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            // NOTE: the two data entries are reset because the head drives
            // out_data directly and must read as zero out of reset; this
            // costs nothing at two entries, unlike a real RAM.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values; blocking here would let the pointer update
            // leak into the occupancy math of the same edge.
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= r_occ + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    assign o_head = r_mem[r_rd_ptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// fifo_burst_rd_ctrl: read-side burst scheduler for the 8-in/16-out async
// FIFO. Requests a downstream burst slot once enough words are queued, then
// drains exactly the granted burst through a valid/ready stream.
// Build option: FIFO_BURST_FLUSH_EN enables forcing a partial burst after
// FLUSH_TIMEOUT idle cycles with a non-empty, below-threshold FIFO.
module fifo_burst_rd_ctrl
    import fifo_burst_pkg::*;
#(
    parameter int RD_DATA_WIDTH  = 16,
    parameter int RD_DEPTH_WIDTH = RD_DEPTH_WIDTH_DEF,
    parameter int BURST_LEN      = 64,
    parameter int FLUSH_TIMEOUT  = 1024
) (
    input  logic                      clk,
    input  logic                      tb_rst,
    input  logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    input  logic                      rd_empty,
    input  logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_en,
    output logic                      burst_req,
    output logic [RD_DEPTH_WIDTH:0]   burst_len,
    input  logic                      burst_ack,
    output logic [RD_DATA_WIDTH-1:0]  out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      burst_done
);

    localparam int               LVL_W       = lvl_width(RD_DEPTH_WIDTH);
    localparam logic [LVL_W-1:0] BURST_LEN_L = LVL_W'(BURST_LEN);
    localparam logic [LVL_W-1:0] ONE_L       = LVL_W'(1);

    burst_state_t       r_state;
    burst_state_t       w_state_nxt;
    logic [LVL_W-1:0]   r_burst_len;
    logic [LVL_W-1:0]   r_issue_cnt;
    logic [LVL_W-1:0]   r_beat_cnt;
    logic               r_inflight;

    logic               w_start;
    logic [LVL_W-1:0]   w_start_len;
    logic               w_hs;
    logic               w_rd_en;
    logic               w_room;
    logic [1:0]         w_occ;
    logic [1:0]         w_occ_after;
    logic [RD_DATA_WIDTH-1:0] w_head;
    logic               w_flush_fire;

    // Skid buffer: the word requested last cycle is written this cycle.
    fifo_skid_buf #(
        .DATA_W (RD_DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .tb_rst      (tb_rst),
        .i_push      (r_inflight),
        .i_push_data (rd_data),
        .i_pop       (w_hs),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    assign w_hs = out_valid && out_ready;

    // Room is judged on the occupancy left after this cycle's pop, so a head
    // leaving in the same cycle frees its slot and reads can stream at one
    // word per cycle. Held words plus the in-flight read never exceed two.
    assign w_occ_after = w_occ - {1'b0, w_hs};
    assign w_room      = (w_occ_after + {1'b0, r_inflight}) < 2'd2;
    assign w_rd_en     = (r_state == XFER) && !rd_empty &&
                         (r_issue_cnt != '0) && w_room;

`ifdef FIFO_BURST_FLUSH_EN
    localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              w_partial;

    assign w_partial    = (rd_water_level != '0) && (rd_water_level < BURST_LEN_L);
    assign w_flush_fire = w_partial && (r_idle_cnt == IDLE_W'(FLUSH_TIMEOUT - 1));

    // Idle timer: counts IDLE cycles spent holding a partial burst.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state != IDLE) || !w_partial || w_flush_fire) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end
`else
    // Only full bursts are issued; residual words wait for more data.
    logic w_unused_flush_cfg;
    assign w_unused_flush_cfg = (FLUSH_TIMEOUT != 0);
    assign w_flush_fire       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and burst start decision.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a value held (no latches).
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_start_len = BURST_LEN_L;
        case (r_state)
            IDLE: begin
                if (rd_water_level >= BURST_LEN_L) begin
                    w_start     = 1'b1;
                    w_state_nxt = REQ;
                end else if (w_flush_fire) begin
                    w_start     = 1'b1;
                    w_start_len = rd_water_level;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (burst_ack) begin
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_hs && (r_beat_cnt == ONE_L)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Burst length latch, issue/beat counters and in-flight read tracking.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            r_burst_len <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_start) begin
                r_burst_len <= w_start_len;
            end
            if ((r_state == REQ) && burst_ack) begin
                r_issue_cnt <= r_burst_len;
                r_beat_cnt  <= r_burst_len;
            end else begin
                if (w_rd_en) begin
                    r_issue_cnt <= r_issue_cnt - ONE_L;
                end
                if (w_hs && (r_beat_cnt != '0)) begin
                    r_beat_cnt <= r_beat_cnt - ONE_L;
                end
            end
        end
    end

    assign rd_en      = w_rd_en;
    assign burst_req  = (r_state == REQ);
    assign burst_len  = r_burst_len;
    assign burst_done = (r_state == DONE);
    assign out_valid  = (w_occ != 2'd0);
    assign out_data   = w_head;
    assign out_last   = (r_state == XFER) && (r_beat_cnt == ONE_L);

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// tb_fifo_burst_rd_ctrl: directed bench for fifo_burst_rd_ctrl with a
// behavioural FIFO read port and a scoreboard of written words.
// Honours FIFO_BURST_FLUSH_EN for the partial-burst scenario.
module tb_fifo_burst_rd_ctrl;

    localparam int DW = 16;
    localparam int AW = 13;
    localparam int LW = AW + 1;
    localparam int BL = 32;
    localparam int FT = 1024;

    logic          clk = 1'b0;
    logic          tb_rst;
    logic [LW-1:0] rd_water_level;
    logic          rd_empty;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic          burst_req;
    logic [LW-1:0] burst_len;
    logic          burst_ack;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          burst_done;

    fifo_burst_rd_ctrl #(
        .RD_DATA_WIDTH  (DW),
        .RD_DEPTH_WIDTH (AW),
        .BURST_LEN      (BL),
        .FLUSH_TIMEOUT  (FT)
    ) dut (
        .clk            (clk),
        .tb_rst         (tb_rst),
        .rd_water_level (rd_water_level),
        .rd_empty       (rd_empty),
        .rd_data        (rd_data),
        .rd_en          (rd_en),
        .burst_req      (burst_req),
        .burst_len      (burst_len),
        .burst_ack      (burst_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .burst_done     (burst_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] wr_word = 16'h1000;
    int            hidden = 0;
    int            outstanding = 0;
    int            rd_count = 0;
    int            empty_at = -1;
    int            empty_hold = 0;

    logic          s_rd_en, s_valid, s_hs, s_last, s_req, s_done, s_empty;
    logic [DW-1:0] s_data;
    int            s_cyc;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic update_fifo_if();
        int vis;
        vis = fifo_q.size() - hidden;
        if (vis < 0) vis = 0;
        rd_water_level = LW'(vis);
        rd_empty       = (vis == 0);
    endtask

    task automatic write_words(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(wr_word);
            sb_q.push_back(wr_word);
            wr_word = wr_word + 16'h0137;
        end
        update_fifo_if();
    endtask

    // One clock cycle: called at a falling edge with inputs already driven.
    task automatic step();
        logic [DW-1:0] exp_w;
        #3;
        s_rd_en = rd_en;   s_valid = out_valid; s_hs    = out_valid && out_ready;
        s_data  = out_data; s_last = out_last;  s_req   = burst_req;
        s_done  = burst_done; s_empty = rd_empty; s_cyc = cyc;
        check("rd_en_while_empty", s_rd_en && s_empty, 1'b0);
        check("held_plus_inflight_le2", outstanding <= 2, 1'b1);
        if (prev_stall) begin
            check("stall_valid", s_valid, 1'b1);
            check("stall_data", s_data, prev_data);
            check("stall_last", s_last, prev_last);
        end
        prev_stall = s_valid && !out_ready;
        prev_data  = s_data;
        prev_last  = s_last;
        if (s_hs) begin
            if (sb_q.size() == 0) begin
                check("extra_beat", s_hs, 1'b0);
            end else begin
                exp_w = sb_q.pop_front();
                check("out_data", s_data, exp_w);
            end
            outstanding--;
        end
        @(posedge clk);
        #1;
        if (s_rd_en) begin
            if (fifo_q.size() != 0) rd_data = fifo_q.pop_front();
            outstanding++;
            rd_count++;
        end
        if (s_rd_en && (rd_count == empty_at)) begin
            hidden     = fifo_q.size();
            empty_hold = 8;
        end else if (empty_hold > 0) begin
            empty_hold--;
            if (empty_hold == 0) hidden = 0;
        end
        update_fifo_if();
        cyc++;
        @(negedge clk);
    endtask

    // Wait for a request, grant it and drain the burst.
    // mode 0: ready held high, 1: ready toggles, 2: ready high (empty window).
    // abort_at > 0 returns right after that many beats are accepted.
    task automatic do_burst(input int len, input int mode, input int abort_at,
                            output int wait_n);
        int  n_ack, first_rd, first_vld, last_hs, done_cyc, beats;
        logic tgl;
        first_rd = -1; first_vld = -1; last_hs = -1; done_cyc = -1; beats = 0;
        tgl = 1'b1; rd_count = 0; wait_n = 0;
        out_ready = 1'b1;
        while (!burst_req && wait_n < 2000) begin
            step();
            wait_n++;
        end
        check("req_seen", burst_req, 1'b1);
        if (!burst_req) return;
        check("burst_len", burst_len, len);
        burst_ack = 1'b1;
        n_ack = cyc;
        step();
        burst_ack = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (mode == 1) begin
                out_ready = tgl;
                tgl = ~tgl;
            end else begin
                out_ready = 1'b1;
            end
            step();
            if (s_rd_en && first_rd < 0) first_rd = s_cyc;
            if (s_valid && first_vld < 0) first_vld = s_cyc;
            if (s_hs) begin
                check("out_last", s_last, (beats + 1) == len);
                beats++;
                last_hs = s_cyc;
                if (abort_at > 0 && beats == abort_at) return;
            end
            if (s_done) begin
                done_cyc = s_cyc;
                break;
            end
        end
        check("done_seen", done_cyc >= 0, 1'b1);
        check("beat_count", beats, len);
        check("done_after_last_hs", done_cyc - last_hs, 1);
        if (mode == 0) begin
            check("ack_to_first_rd", first_rd - n_ack, 1);
            check("ack_to_first_valid", first_vld - n_ack, 3);
            check("first_rd_to_done", done_cyc - first_rd, len + 2);
        end
        step();
        check("done_one_cycle", s_done, 1'b0);
        check("valid_after_done", s_valid, 1'b0);
    endtask

    initial begin
        int  wait_n;
        logic saw;
        tb_rst    = 1'b1;
        burst_ack = 1'b0;
        out_ready = 1'b0;
        rd_data   = '0;
        update_fifo_if();
        repeat (2) @(negedge clk);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_burst_req", burst_req, 1'b0);
        check("rst_burst_len", burst_len, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_burst_done", burst_done, 1'b0);
        tb_rst = 1'b0;
        @(negedge clk);

        // Threshold: 31 words do not start a burst, the 32nd does.
        write_words(BL - 1);
        saw = 1'b0;
        repeat (5) begin
            step();
            if (s_req) saw = 1'b1;
        end
        check("below_thresh_no_req", saw, 1'b0);
        write_words(1);
        do_burst(BL, 0, 0, wait_n);
        check("req_latency", wait_n, 1);

        // 64 words drained as two bursts with out_ready toggling.
        write_words(2 * BL);
        do_burst(BL, 1, 0, wait_n);
        do_burst(BL, 1, 0, wait_n);

        // FIFO runs dry after word 10 for a while, then refills.
        write_words(BL);
        empty_at = 10;
        do_burst(BL, 2, 0, wait_n);
        empty_at = -1;

        // Reset during transfer after five beats.
        write_words(BL);
        do_burst(BL, 0, 5, wait_n);
        tb_rst = 1'b1;
        #1;
        check("midrst_rd_en", rd_en, 1'b0);
        check("midrst_burst_req", burst_req, 1'b0);
        check("midrst_burst_len", burst_len, 0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_last", out_last, 1'b0);
        check("midrst_burst_done", burst_done, 1'b0);
        fifo_q.delete();
        sb_q.delete();
        hidden = 0; outstanding = 0; empty_hold = 0; prev_stall = 1'b0;
        rd_data = '0;
        update_fifo_if();
        @(negedge clk);
        tb_rst = 1'b0;
        saw = 1'b0;
        repeat (20) begin
            step();
            if (s_done || s_req || s_rd_en || s_valid) saw = 1'b1;
        end
        check("post_rst_quiet", saw, 1'b0);

        // Ten residual words below the burst threshold.
        write_words(10);
`ifdef FIFO_BURST_FLUSH_EN
        do_burst(10, 0, 0, wait_n);
        check("flush_wait_window", (wait_n >= 1023) && (wait_n <= 1026), 1'b1);
`else
        saw = 1'b0;
        repeat (5000) begin
            step();
            if (s_req) saw = 1'b1;
        end
        check("no_flush_req", saw, 1'b0);
        check("residual_level", rd_water_level, 10);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
